// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pacman_pkg
//  Brief    : Shared maze geometry, direction encodings and wall lookup.
//  Revision : 1.0
// ============================================================================
package pacman_pkg;

    localparam int GRID_W  = 10;
    localparam int GRID_H  = 10;
    localparam int COORD_W = 10;

    localparam logic WALL = 1'b1;
    localparam logic PATH = 1'b0;

    typedef enum logic [1:0] {
        DIR_U = 2'b00,
        DIR_D = 2'b01,
        DIR_L = 2'b10,
        DIR_R = 2'b11
    } dir_t;

    // MAZE[y][x]: border ring, rows 2/4/6 cols 2-4, (x6,y4) and (x7,y7)
    localparam logic [GRID_H-1:0][GRID_W-1:0] MAZE = {
        10'h3FF,   // y9
        10'h201,   // y8
        10'h281,   // y7
        10'h21D,   // y6
        10'h201,   // y5
        10'h25D,   // y4
        10'h201,   // y3
        10'h21D,   // y2
        10'h201,   // y1
        10'h3FF    // y0
    };

    // Anything off-grid reads as wall, so neighbour arithmetic never wraps.
    function automatic logic is_wall(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
        if ((x >= COORD_W'(GRID_W)) || (y >= COORD_W'(GRID_H)))
            return WALL;
        return MAZE[y[3:0]][x[3:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_chaser_if.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_chaser_if
//  Brief    : Pacman position in, ghost position/status out.
//  Revision : 1.0
// ============================================================================
interface ghost_chaser_if;

    logic                             enable_i;
    logic [pacman_pkg::COORD_W-1:0]   pacman_x_i;
    logic [pacman_pkg::COORD_W-1:0]   pacman_y_i;
    logic [pacman_pkg::COORD_W-1:0]   ghost_x;
    logic [pacman_pkg::COORD_W-1:0]   ghost_y;
    logic [1:0]                       ghost_dir;
    logic                             mode_o;
    logic                             step_o;
    logic                             caught_o;

    modport master (
        output enable_i, pacman_x_i, pacman_y_i,
        input  ghost_x, ghost_y, ghost_dir, mode_o, step_o, caught_o
    );

    modport slave (
        input  enable_i, pacman_x_i, pacman_y_i,
        output ghost_x, ghost_y, ghost_dir, mode_o, step_o, caught_o
    );

endinterface
`default_nettype wire

// File: rtl/maze_rom.sv
`default_nettype none
// ============================================================================
//  Module   : maze_rom
//  Brief    : Combinational multi-port wall lookup into the shared maze.
//  Revision : 1.0
// ============================================================================
module maze_rom
    import pacman_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0][COORD_W-1:0] i_x,
    input  logic [NUM_PORTS-1:0][COORD_W-1:0] i_y,
    output logic [NUM_PORTS-1:0]              o_wall
);

    genvar g_i;
    generate
        for (g_i = 0; g_i < NUM_PORTS; g_i++) begin : g_port
            assign o_wall[g_i] = is_wall(i_x[g_i], i_y[g_i]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ghost_chaser.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_chaser
//  Brief    : One ghost that steps toward pacman (or its scatter corner).
//  Revision : 1.0
// ============================================================================
module ghost_chaser
    import pacman_pkg::*;
#(
    parameter int STEP_TICKS    = 50000,
    parameter int CHASE_STEPS   = 20,
    parameter int SCATTER_STEPS = 7,
    parameter int START_X       = 8,
    parameter int START_Y       = 8,
    parameter int SCAT_X        = 1,
    parameter int SCAT_Y        = 1
) (
    input  logic           clk_i,
    input  logic           reset_n,
    ghost_chaser_if.slave  bus
);

    localparam int TICK_W     = $clog2(STEP_TICKS);
    localparam int STEPS_MAX  = (CHASE_STEPS > SCATTER_STEPS) ? CHASE_STEPS : SCATTER_STEPS;
    localparam int STEP_CNT_W = $clog2(STEPS_MAX + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_CAUGHT = 2'd2;

    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(STEP_TICKS - 1);

    logic [1:0]             r_state;
    logic [TICK_W-1:0]      r_tick;
    logic [COORD_W-1:0]     r_gx;
    logic [COORD_W-1:0]     r_gy;
    logic [1:0]             r_dir;
    logic                   r_mode;
    logic [STEP_CNT_W-1:0]  r_steps;
    logic                   r_step;
    logic                   r_caught;

    logic [COORD_W-1:0]     w_tx;
    logic [COORD_W-1:0]     w_ty;
    logic signed [10:0]     w_dx;
    logic signed [10:0]     w_dy;
    logic [10:0]            w_adx;
    logic [10:0]            w_ady;
    logic                   w_pri_vert;
    logic [3:0][COORD_W-1:0] w_nx;
    logic [3:0][COORD_W-1:0] w_ny;
    logic [3:0]             w_wall;
    logic [1:0]             w_rev_dir;
    logic [5:0]             w_cand_ok;
    logic [5:0][1:0]        w_cand;
    logic                   w_move;
    logic [1:0]             w_next_dir;
    logic                   w_pac_valid;
    logic                   w_match;
    logic [STEP_CNT_W-1:0]  w_steps_inc;
    logic [STEP_CNT_W-1:0]  w_steps_limit;

    assign w_tx = r_mode ? COORD_W'(SCAT_X) : bus.pacman_x_i;
    assign w_ty = r_mode ? COORD_W'(SCAT_Y) : bus.pacman_y_i;
    assign w_dx = $signed({1'b0, w_tx}) - $signed({1'b0, r_gx});
    assign w_dy = $signed({1'b0, w_ty}) - $signed({1'b0, r_gy});
    assign w_adx = w_dx[10] ? 11'(-w_dx) : 11'(w_dx);
    assign w_ady = w_dy[10] ? 11'(-w_dy) : 11'(w_dy);
    assign w_pri_vert = (w_ady >= w_adx);
    assign w_rev_dir  = {r_dir[1], ~r_dir[0]};

    assign w_pac_valid = (bus.pacman_x_i < COORD_W'(GRID_W)) &&
                         (bus.pacman_y_i < COORD_W'(GRID_H));
    assign w_match     = (r_gx == bus.pacman_x_i) && (r_gy == bus.pacman_y_i);

    assign w_steps_inc   = r_steps + 1'b1;
    assign w_steps_limit = r_mode ? STEP_CNT_W'(SCATTER_STEPS) : STEP_CNT_W'(CHASE_STEPS);

    // Neighbour tiles indexed by direction encoding.
    always_comb begin
        w_nx = '0;
        w_ny = '0;
        w_nx[DIR_U] = r_gx;         w_ny[DIR_U] = r_gy - 1'b1;
        w_nx[DIR_D] = r_gx;         w_ny[DIR_D] = r_gy + 1'b1;
        w_nx[DIR_L] = r_gx - 1'b1;  w_ny[DIR_L] = r_gy;
        w_nx[DIR_R] = r_gx + 1'b1;  w_ny[DIR_R] = r_gy;
    end

    maze_rom #(
        .NUM_PORTS (4)
    ) u_maze_rom (
        .i_x    (w_nx),
        .i_y    (w_ny),
        .o_wall (w_wall)
    );

    // Candidate list in priority order: primary axis, secondary axis, U,L,D,R.
    always_comb begin
        w_cand_ok = 6'b111111;
        w_cand    = '0;
        if (w_pri_vert) begin
            w_cand[0]    = w_dy[10] ? DIR_U : DIR_D;
            w_cand_ok[0] = (w_dy != '0);
            w_cand[1]    = w_dx[10] ? DIR_L : DIR_R;
            w_cand_ok[1] = (w_dx != '0);
        end else begin
            w_cand[0]    = w_dx[10] ? DIR_L : DIR_R;
            w_cand_ok[0] = (w_dx != '0);
            w_cand[1]    = w_dy[10] ? DIR_U : DIR_D;
            w_cand_ok[1] = (w_dy != '0);
        end
        w_cand[2] = DIR_U;
        w_cand[3] = DIR_L;
        w_cand[4] = DIR_D;
        w_cand[5] = DIR_R;
    end

    // Reversing is only a last resort; a fully boxed-in ghost stays put.
    always_comb begin
        w_move     = 1'b0;
        w_next_dir = r_dir;
        for (int i = 0; i < 6; i++) begin
            if (!w_move && w_cand_ok[i] && (w_wall[w_cand[i]] == PATH) &&
                (w_cand[i] != w_rev_dir)) begin
                w_move     = 1'b1;
                w_next_dir = w_cand[i];
            end
        end
        if (!w_move && (w_wall[w_rev_dir] == PATH)) begin
            w_move     = 1'b1;
            w_next_dir = w_rev_dir;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_tick   <= '0;
            r_gx     <= COORD_W'(START_X);
            r_gy     <= COORD_W'(START_Y);
            r_dir    <= DIR_L;
            r_mode   <= 1'b0;
            r_steps  <= '0;
            r_step   <= 1'b0;
            r_caught <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.enable_i)
                        r_state <= c_RUN;
                end
                c_RUN: begin
                    if (bus.enable_i) begin
                        if (w_match) begin
                            r_state  <= c_CAUGHT;
                            r_caught <= 1'b1;
                        end else if (r_tick == c_TICK_LAST) begin
                            r_tick <= '0;
                            if (w_pac_valid && w_move) begin
                                r_gx   <= w_nx[w_next_dir];
                                r_gy   <= w_ny[w_next_dir];
                                r_dir  <= w_next_dir;
                                r_step <= 1'b1;
                                if (w_steps_inc == w_steps_limit) begin
                                    r_mode  <= ~r_mode;
                                    r_steps <= '0;
                                end else begin
                                    r_steps <= w_steps_inc;
                                end
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_CAUGHT;
                end
            endcase
        end
    end

    assign bus.ghost_x   = r_gx;
    assign bus.ghost_y   = r_gy;
    assign bus.ghost_dir = r_dir;
    assign bus.mode_o    = r_mode;
    assign bus.step_o    = r_step;
    assign bus.caught_o  = r_caught;

endmodule
`default_nettype wire

// File: tb/tb_ghost_chaser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ghost_chaser
//  Brief    : Directed vectors against hand-traced ghost paths.
//  Revision : 1.0
// ============================================================================
module tb_ghost_chaser;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ghost_chaser_if bus_a ();
    ghost_chaser_if bus_b ();

    ghost_chaser #(
        .STEP_TICKS (4)
    ) u_dut_a (
        .clk_i   (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    ghost_chaser #(
        .STEP_TICKS  (4),
        .CHASE_STEPS (2)
    ) u_dut_b (
        .clk_i   (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where step_o is seen; n = cycles waited.
    task automatic wait_step(input int which, input string tag, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = (which != 0) ? bus_b.step_o : bus_a.step_o;
        end
        check({tag, "_step_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_pos(input int which, input string tag,
                             input int x, input int y, input int d);
        if (which != 0) begin
            check({tag, "_x"},   32'(bus_b.ghost_x),   32'(x));
            check({tag, "_y"},   32'(bus_b.ghost_y),   32'(y));
            check({tag, "_dir"}, 32'(bus_b.ghost_dir), 32'(d));
        end else begin
            check({tag, "_x"},   32'(bus_a.ghost_x),   32'(x));
            check({tag, "_y"},   32'(bus_a.ghost_y),   32'(y));
            check({tag, "_dir"}, 32'(bus_a.ghost_dir), 32'(d));
        end
    endtask

    initial begin
        int n;
        int steps_seen;
        int moved;

        reset_n          = 1'b1;
        bus_a.enable_i   = 1'b0;
        bus_a.pacman_x_i = 10'd5;
        bus_a.pacman_y_i = 10'd8;
        bus_b.enable_i   = 1'b0;
        bus_b.pacman_x_i = 10'd1;
        bus_b.pacman_y_i = 10'd8;

        // Reset values
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check_pos(0, "rst", 8, 8, 2);
        check("rst_mode",   32'(bus_a.mode_o),   32'd0);
        check("rst_step",   32'(bus_a.step_o),   32'd0);
        check("rst_caught", 32'(bus_a.caught_o), 32'd0);

        // Straight chase along row 8 into pacman at (5,8)
        bus_a.enable_i = 1'b1;
        wait_step(0, "c1", n);
        check("c1_latency", 32'(n), 32'd5);
        check_pos(0, "c1", 7, 8, 2);
        wait_step(0, "c2", n);
        check("c2_interval", 32'(n), 32'd4);
        check_pos(0, "c2", 6, 8, 2);
        wait_step(0, "c3", n);
        check("c3_interval", 32'(n), 32'd4);
        check_pos(0, "c3", 5, 8, 2);
        check("c3_caught_early", 32'(bus_a.caught_o), 32'd0);
        @(negedge clk);
        check("caught_asserts", 32'(bus_a.caught_o), 32'd1);
        check("caught_no_step", 32'(bus_a.step_o),   32'd0);
        steps_seen = 0;
        moved      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.step_o) steps_seen++;
            if (bus_a.ghost_x != 10'd5 || bus_a.ghost_y != 10'd8) moved++;
        end
        check("caught_steps", 32'(steps_seen), 32'd0);
        check("caught_moved", 32'(moved),      32'd0);
        check("caught_held",  32'(bus_a.caught_o), 32'd1);

        // Reset while caught
        bus_a.enable_i = 1'b0;
        reset_n        = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        check_pos(0, "rst2", 8, 8, 2);
        check("rst2_caught", 32'(bus_a.caught_o), 32'd0);
        steps_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_a.step_o) steps_seen++;
        end
        check("idle_no_step", 32'(steps_seen), 32'd0);

        // Diagonal target: tie goes vertical, then wall at (7,7) forces U
        bus_a.pacman_x_i = 10'd3;
        bus_a.pacman_y_i = 10'd3;
        bus_a.enable_i   = 1'b1;
        wait_step(0, "d1", n);
        check("d1_latency", 32'(n), 32'd5);
        check_pos(0, "d1", 8, 7, 0);
        wait_step(0, "d2", n);
        check_pos(0, "d2", 8, 6, 0);

        // Pause at tick 2 for 10 clocks, then two more ticks to the step
        @(negedge clk);
        @(negedge clk);
        bus_a.enable_i = 1'b0;
        steps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.step_o) steps_seen++;
        end
        check("pause_steps", 32'(steps_seen), 32'd0);
        check_pos(0, "pause", 8, 6, 0);
        bus_a.enable_i = 1'b1;
        @(negedge clk);
        check("resume_t1", 32'(bus_a.step_o), 32'd0);
        @(negedge clk);
        check("resume_t2", 32'(bus_a.step_o), 32'd1);
        check_pos(0, "resume", 7, 6, 2);

        // Off-grid pacman: ghost holds, no step pulses
        bus_a.pacman_x_i = 10'd12;
        steps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_a.step_o) steps_seen++;
        end
        check("offgrid_steps", 32'(steps_seen), 32'd0);
        check_pos(0, "offgrid", 7, 6, 2);
        check("offgrid_mode", 32'(bus_a.mode_o), 32'd0);

        // CHASE_STEPS=2 instance: chase twice, scatter 7 steps toward (1,1)
        bus_b.enable_i = 1'b1;
        wait_step(1, "m1", n);
        check_pos(1, "m1", 7, 8, 2);
        check("m1_mode", 32'(bus_b.mode_o), 32'd0);
        wait_step(1, "m2", n);
        check_pos(1, "m2", 6, 8, 2);
        check("m2_mode", 32'(bus_b.mode_o), 32'd1);
        wait_step(1, "m3", n);
        check_pos(1, "m3", 6, 7, 0);
        for (int i = 4; i <= 8; i++) wait_step(1, "mx", n);
        check_pos(1, "m8", 5, 3, 0);
        check("m8_mode", 32'(bus_b.mode_o), 32'd1);
        wait_step(1, "m9", n);
        check_pos(1, "m9", 4, 3, 2);
        check("m9_mode", 32'(bus_b.mode_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
